link_receiver: RTL and testbench

Receiving end of the dual-rail two-phase (transition-signalled) link. Each bit is carried on two rails: a transition on rail 1 means `1`, a transition on rail 0 means `0`, and the receiver acknowledges each word by toggling a single ack line. The block synchronises the asynchronous rails into the `clk` domain, detects word completion, decodes the data and presents it on a valid/ready port. It toggles `ack_o` only after the word has been consumed, so the link sender sees real backpressure.

---
 rtl/link_pkg.sv | 23 ++
 rtl/link_sync.sv | 30 +++
 rtl/link_receiver.sv | 118 +++++++++++
 tb/tb_link_receiver.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : link_pkg                                                   |
// | Brief   : Shared constants and types for the dual-rail link receiver.|
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package link_pkg;

    localparam int RAIL_NUM = 2;
    localparam int RAIL_0   = 0;
    localparam int RAIL_1   = 1;

    // Two-phase dual-rail is the only encoding this receiver decodes.
    localparam logic [15:0] ENC_TP = "TP";

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        ERR     = 2'd2
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/link_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : link_sync                                                  |
// | Brief   : N-stage, W-bit flop synchroniser, async active-low reset.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module link_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], d};
        end
    end

    assign q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/link_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : link_receiver                                              |
// | Brief   : Two-phase dual-rail link receiver with valid/ready output. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module link_receiver
    import link_pkg::*;
#(
    parameter             ENC         = "TP",
    parameter int         WIDTH       = 1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0]   in,
    output logic                             ack_o,
    output logic [WIDTH-1:0]                 data_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic                             err_o
);

    localparam int RAILS = WIDTH * RAIL_NUM;

    if (ENC != ENC_TP) begin : g_bad_enc
        $error("link_receiver: only the TP encoding is supported");
    end

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("link_receiver: SYNC_STAGES must be at least 2");
    end

    logic [RAILS-1:0] w_sync;
    logic [RAILS-1:0] w_diff;
    logic [WIDTH-1:0] w_complete;
    logic [WIDTH-1:0] w_bad;
    logic [WIDTH-1:0] w_decoded;

    rx_state_t        r_state;
    logic [RAILS-1:0] r_ref;
    logic             r_ack;
    logic             r_valid;
    logic             r_err;
    logic [WIDTH-1:0] r_data;

    link_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (RAILS)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in),
        .q     (w_sync)
    );

    // Rails that moved since the last accepted word.
    assign w_diff = w_sync ^ r_ref;

    for (genvar b = 0; b < WIDTH; b++) begin : g_decode
        assign w_complete[b] = w_diff[b*RAIL_NUM + RAIL_1] ^ w_diff[b*RAIL_NUM + RAIL_0];
        assign w_bad[b]      = w_diff[b*RAIL_NUM + RAIL_1] & w_diff[b*RAIL_NUM + RAIL_0];
        assign w_decoded[b]  = w_diff[b*RAIL_NUM + RAIL_1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
            r_ref   <= '0;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (|w_bad) begin
                        r_err   <= 1'b1;
                        r_state <= ERR;
                    end else if (&w_complete) begin
                        r_data  <= w_decoded;
                        r_ref   <= w_sync;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    // A new transition before our ack beats a same-cycle handshake.
                    if (|w_diff) begin
                        r_err   <= 1'b1;
                        r_valid <= 1'b0;
                        r_state <= ERR;
                    end else if (r_valid && ready_i) begin
                        r_valid <= 1'b0;
                        r_ack   <= ~r_ack;
                        r_state <= COLLECT;
                    end
                end
                ERR: begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b1;
                    r_state <= ERR;
                end
            endcase
        end
    end

    assign ack_o   = r_ack;
    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_link_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_link_receiver                                           |
// | Brief   : Self-checking bench for link_receiver, WIDTH=4.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_link_receiver;
    import link_pkg::*;

    localparam int W  = 4;
    localparam int SS = 2;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [W-1:0][RAIL_NUM-1:0] rails = '0;
    logic                       ready = 1'b0;
    logic                       ack;
    logic                       valid;
    logic                       err;
    logic [W-1:0]               data;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_ack = 1'b0;
    int   ack_edges = 0;
    logic ack_seen = 1'b0;

    typedef struct {
        logic [W-1:0] word;
        int           stall;
        logic [W-1:0] exp_data;
        int           exp_lat;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    link_receiver #(
        .ENC         ("TP"),
        .WIDTH       (W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (rails),
        .ack_o   (ack),
        .data_o  (data),
        .valid_o (valid),
        .ready_i (ready),
        .err_o   (err)
    );

    always @(negedge clk) begin
        if (ack !== ack_seen) begin
            ack_edges = ack_edges + 1;
            ack_seen  = ack;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Two-phase sender: a bit is sent by flipping the rail that names its value.
    task automatic send(input logic [W-1:0] w, input logic [W-1:0] mask);
        for (int b = 0; b < W; b++)
            if (mask[b]) rails[b][w[b]] = ~rails[b][w[b]];
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        rails   = '0;
        ready   = 1'b0;
        exp_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic expect_word(input logic [W-1:0] w, input string tag);
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (e < 3) check({tag, " valid early"}, valid, 1'b0);
        end
        check({tag, " valid"}, valid, 1'b1);
        check({tag, " data"}, data, w);
    endtask

    task automatic handshake(input string tag);
        ready = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        check({tag, " ack toggle"}, ack, exp_ack);
        check({tag, " valid clear"}, valid, 1'b0);
        ready = 1'b0;
    endtask

    initial begin
        int           edges0;
        logic         a0;

        vecs[0] = '{word: 4'hA, stall: 0, exp_data: 4'hA, exp_lat: 3};
        vecs[1] = '{word: 4'h5, stall: 5, exp_data: 4'h5, exp_lat: 3};
        vecs[2] = '{word: 4'hF, stall: 5, exp_data: 4'hF, exp_lat: 3};
        vecs[3] = '{word: 4'h0, stall: 5, exp_data: 4'h0, exp_lat: 3};

        // Reset with junk on the rails, then release with the sender idle.
        rst_n = 1'b0;
        rails = W*RAIL_NUM'($urandom);
        ready = 1'($urandom_range(0, 1));
        tick();
        tick();
        check("rst ack", ack, 1'b0);
        check("rst valid", valid, 1'b0);
        check("rst data", data, 4'h0);
        check("rst err", err, 1'b0);
        rails = '0;
        ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle valid", valid, 1'b0);
            check("idle ack", ack, 1'b0);
        end
        check("idle err", err, 1'b0);
        ready = 1'b0;

        // Table-driven words, the later ones stalled by backpressure.
        edges0 = ack_edges;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) edges0 = ack_edges;
            send(vecs[i].word, '1);
            for (int c = 1; c <= vecs[i].exp_lat; c++) begin
                tick();
                if (c < vecs[i].exp_lat) check("vec valid early", valid, 1'b0);
            end
            check("vec valid", valid, 1'b1);
            check("vec data", data, vecs[i].exp_data);
            check("vec ack hold", ack, exp_ack);
            for (int s = 0; s < vecs[i].stall; s++) begin
                tick();
                check("stall valid", valid, 1'b1);
                check("stall data", data, vecs[i].exp_data);
                check("stall ack", ack, exp_ack);
            end
            handshake("vec");
            for (int s = 0; s < 3; s++) begin
                tick();
                check("no dup valid", valid, 1'b0);
            end
        end
        check("ack toggles", ack_edges - edges0, 3);

        // Partial word: three of four bits never complete it.
        send(4'h6, 4'b0111);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("partial valid", valid, 1'b0);
        end
        send(4'h6, 4'b1000);
        expect_word(4'h6, "partial");
        handshake("partial");

        // Random words with bits arriving in random cycles and random ready.
        for (int k = 0; k < 30; k++) begin
            logic [W-1:0] w;
            int           d [W];
            int           last;
            int           guard;
            bit           accepted;
            w    = W'($urandom);
            last = 0;
            for (int b = 0; b < W; b++) begin
                d[b] = $urandom_range(0, 3);
                if (d[b] > last) last = d[b];
            end
            for (int c = 0; c <= last; c++) begin
                for (int b = 0; b < W; b++)
                    if (d[b] == c) rails[b][w[b]] = ~rails[b][w[b]];
                ready = 1'($urandom_range(0, 1));
                if (c < last) begin
                    tick();
                    check("rand partial valid", valid, 1'b0);
                end
            end
            for (int e = 1; e <= 3; e++) begin
                ready = 1'($urandom_range(0, 1));
                tick();
                if (e < 3) check("rand valid early", valid, 1'b0);
            end
            check("rand valid", valid, 1'b1);
            check("rand data", data, w);
            guard    = 0;
            accepted = 0;
            while (!accepted) begin
                ready = (guard >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                tick();
                guard++;
                if (ready) begin
                    exp_ack  = ~exp_ack;
                    accepted = 1;
                    check("rand ack", ack, exp_ack);
                    check("rand valid clear", valid, 1'b0);
                end else begin
                    check("rand hold valid", valid, 1'b1);
                    check("rand hold data", data, w);
                    check("rand hold ack", ack, exp_ack);
                end
            end
            ready = 1'b0;
        end
        check("rand err", err, 1'b0);

        // Both rails of bit 1 flip while collecting.
        do_reset();
        rails[1] = ~rails[1];
        for (int e = 0; e < 3; e++) tick();
        check("dual err", err, 1'b1);
        check("dual valid", valid, 1'b0);
        send(4'h9, '1);
        ready = 1'b1;
        for (int e = 0; e < 6; e++) tick();
        check("dual sticky err", err, 1'b1);
        check("dual sticky valid", valid, 1'b0);
        check("dual ack", ack, 1'b0);
        do_reset();
        check("dual cleared", err, 1'b0);

        // Early transition while holding, coinciding with the handshake.
        send(4'h3, '1);
        expect_word(4'h3, "hold");
        a0 = ack;
        send(4'h0, 4'b0100);
        ready = 1'b0;
        tick();
        tick();
        ready = 1'b1;
        tick();
        check("hold err", err, 1'b1);
        check("hold ack", ack, a0);
        check("hold valid", valid, 1'b0);
        tick();
        check("hold ack after", ack, a0);
        ready = 1'b0;

        // Reset dropped mid-word, then sender and receiver restart together.
        do_reset();
        send(4'hA, '1);
        expect_word(4'hA, "mid");
        handshake("mid");
        send(4'h5, '1);
        expect_word(4'h5, "mid2");
        check("mid ack one", ack, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async ack", ack, 1'b0);
        check("async valid", valid, 1'b0);
        check("async data", data, 4'h0);
        rails   = '0;
        exp_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(4'hC, '1);
        expect_word(4'hC, "after");
        handshake("after");
        check("after err", err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
